// File: rtl/pp_row_accumulator_pkg.sv
// Shared types and constants for the partial-product row accumulator.
// Provides lane/index widths, the accumulator FSM state type and the
// default modulus used by the modular adders.
package lwe_pkg;

    localparam int LANE_W = 16;
    localparam int IDX_W  = 10;

    localparam int unsigned Q_DEFAULT     = 3329;
    localparam int unsigned DEPTH_DEFAULT = 100;

    typedef logic [LANE_W-1:0] lane_t;
    typedef logic [IDX_W-1:0]  idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_t;

    // True when a lane value is a valid residue (strictly below the modulus).
    function automatic logic lane_in_range(input lane_t v, input lane_t q);
        return (v < q);
    endfunction

endpackage

// File: rtl/pp_row_accumulator_mod_add_q.sv
// Combinational modular adder: (a + b) mod Q for operands already below Q.
// With Q < 2^15 the 16-bit raw sum cannot overflow, so a single
// conditional subtract is enough to bring the result back below Q.
module mod_add_q
    import lwe_pkg::*;
#(
    parameter int unsigned Q = Q_DEFAULT
) (
    input  logic [LANE_W-1:0] a_i,
    input  logic [LANE_W-1:0] b_i,
    output logic [LANE_W-1:0] sum_o
);

    localparam lane_t Q_L = lane_t'(Q);

    lane_t raw_sum;

    // Plain add followed by one conditional subtract of Q.
    always_comb begin
        raw_sum = a_i + b_i;
        sum_o   = (raw_sum >= Q_L) ? (raw_sum - Q_L) : raw_sum;
    end

endmodule

// File: rtl/pp_row_accumulator.sv
// Row accumulator for the masked partial-product stream.
// Stage 1 reduces each beat's lane pair mod Q and range-checks it.
// Stage 2 is the IDLE/ACCUM sequencer that sums DEPTH beats of one row and
// enforces the index/tag sequence. Stage 3 registers the emitted row sum.
// Optional feature macro PP_ERROR_TERM_EN adds the e_in error term, which is
// sampled with the last beat of a row and added to the row sum at emit time.
// Valid semantics: there is no backpressure; every cycle with B_valid=1
// delivers one beat, and sum_valid is a single-cycle pulse per emitted row.
module pp_row_accumulator
    import lwe_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned Q     = Q_DEFAULT
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        B_valid,
    input  logic [9:0]  idx_B,
    input  logic [31:0] B_out,
    input  logic [9:0]  h_in,
`ifdef PP_ERROR_TERM_EN
    input  logic [15:0] e_in,
`endif
    output logic [15:0] sum_out,
    output logic [9:0]  row_out,
    output logic        sum_valid,
    output logic        seq_err,
    output logic        busy
);

    localparam lane_t Q_L      = lane_t'(Q);
    localparam idx_t  LAST_IDX = idx_t'(DEPTH - 1);
    localparam idx_t  ONE_IDX  = idx_t'(1);

    // ---------------- Stage 1: lane reduction and range check ----------------
    lane_t lane0;
    lane_t lane1;
    lane_t lane_sum;
    logic  beat_err;

    assign lane0 = B_out[15:0];
    assign lane1 = B_out[31:16];

    mod_add_q #(.Q(Q)) u_lane_add (
        .a_i   (lane0),
        .b_i   (lane1),
        .sum_o (lane_sum)
    );

`ifdef PP_ERROR_TERM_EN
    // The error term only matters on the closing beat of a row.
    assign beat_err = !lane_in_range(lane0, Q_L) || !lane_in_range(lane1, Q_L) ||
                      ((idx_B == LAST_IDX) && !lane_in_range(e_in, Q_L));
`else
    assign beat_err = !lane_in_range(lane0, Q_L) || !lane_in_range(lane1, Q_L);
`endif

    logic  s1_valid_q;
    idx_t  s1_idx_q;
    idx_t  s1_h_q;
    lane_t s1_sum_q;
    logic  s1_err_q;
`ifdef PP_ERROR_TERM_EN
    lane_t s1_e_q;
`endif

    // Stage-1 pipeline register: reduced lane sum plus beat metadata.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            s1_h_q     <= '0;
            s1_sum_q   <= '0;
            s1_err_q   <= 1'b0;
`ifdef PP_ERROR_TERM_EN
            s1_e_q     <= '0;
`endif
        end else begin
            s1_valid_q <= B_valid;
            s1_idx_q   <= idx_B;
            s1_h_q     <= h_in;
            s1_sum_q   <= lane_sum;
            s1_err_q   <= beat_err;
`ifdef PP_ERROR_TERM_EN
            s1_e_q     <= e_in;
`endif
        end
    end

    // ---------------- Stage 2: row sequencer ----------------
    acc_state_t state_q, state_d;
    lane_t      acc_q, acc_d;
    idx_t       cur_row_q, cur_row_d;
    idx_t       expect_q, expect_d;
    logic       seq_err_q, seq_err_d;
    logic       fin_valid_q, fin_valid_d;
    lane_t      fin_sum_q, fin_sum_d;
    idx_t       fin_row_q, fin_row_d;
`ifdef PP_ERROR_TERM_EN
    lane_t      fin_e_q, fin_e_d;
`endif

    lane_t acc_add;
    logic  start_ok;
    logic  in_seq;

    mod_add_q #(.Q(Q)) u_acc_add (
        .a_i   (acc_q),
        .b_i   (s1_sum_q),
        .sum_o (acc_add)
    );

    // A clean idx=0 beat may always open a row; in_seq is the next expected beat.
    assign start_ok = !s1_err_q && (s1_idx_q == '0);
    assign in_seq   = !s1_err_q && (s1_idx_q == expect_q) && (s1_h_q == cur_row_q);

    // Next-state logic: open, extend, close or abandon the current row.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cur_row_d   = cur_row_q;
        expect_d    = expect_q;
        seq_err_d   = seq_err_q;
        fin_valid_d = 1'b0;
        fin_sum_d   = fin_sum_q;
        fin_row_d   = fin_row_q;
`ifdef PP_ERROR_TERM_EN
        fin_e_d     = fin_e_q;
`endif
        if (s1_valid_q) begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        if (DEPTH == 1) begin
                            // Single-beat rows close on the beat that opens them.
                            fin_valid_d = 1'b1;
                            fin_sum_d   = s1_sum_q;
                            fin_row_d   = s1_h_q;
`ifdef PP_ERROR_TERM_EN
                            fin_e_d     = s1_e_q;
`endif
                        end else begin
                            acc_d     = s1_sum_q;
                            cur_row_d = s1_h_q;
                            expect_d  = ONE_IDX;
                            state_d   = ACCUM;
                        end
                    end else begin
                        seq_err_d = 1'b1;
                    end
                end
                ACCUM: begin
                    if (in_seq) begin
                        if (s1_idx_q == LAST_IDX) begin
                            fin_valid_d = 1'b1;
                            fin_sum_d   = acc_add;
                            fin_row_d   = cur_row_q;
`ifdef PP_ERROR_TERM_EN
                            fin_e_d     = s1_e_q;
`endif
                            state_d     = IDLE;
                        end else begin
                            acc_d    = acc_add;
                            expect_d = expect_q + ONE_IDX;
                        end
                    end else begin
                        // Partial row is discarded; a clean idx=0 beat restarts.
                        seq_err_d = 1'b1;
                        if (start_ok) begin
                            acc_d     = s1_sum_q;
                            cur_row_d = s1_h_q;
                            expect_d  = ONE_IDX;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Sequencer state, accumulator and closing-row registers.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cur_row_q   <= '0;
            expect_q    <= '0;
            seq_err_q   <= 1'b0;
            fin_valid_q <= 1'b0;
            fin_sum_q   <= '0;
            fin_row_q   <= '0;
`ifdef PP_ERROR_TERM_EN
            fin_e_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cur_row_q   <= cur_row_d;
            expect_q    <= expect_d;
            seq_err_q   <= seq_err_d;
            fin_valid_q <= fin_valid_d;
            fin_sum_q   <= fin_sum_d;
            fin_row_q   <= fin_row_d;
`ifdef PP_ERROR_TERM_EN
            fin_e_q     <= fin_e_d;
`endif
        end
    end

    // ---------------- Stage 3: emit register ----------------
    lane_t emit_sum;

`ifdef PP_ERROR_TERM_EN
    mod_add_q #(.Q(Q)) u_err_add (
        .a_i   (fin_sum_q),
        .b_i   (fin_e_q),
        .sum_o (emit_sum)
    );
`else
    assign emit_sum = fin_sum_q;
`endif

    lane_t sum_out_q;
    idx_t  row_out_q;
    logic  sum_valid_q;

    // Output register: pulse sum_valid and hold the last row sum/tag.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            sum_out_q   <= '0;
            row_out_q   <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            sum_valid_q <= fin_valid_q;
            if (fin_valid_q) begin
                sum_out_q <= emit_sum;
                row_out_q <= fin_row_q;
            end
        end
    end

    assign sum_out   = sum_out_q;
    assign row_out   = row_out_q;
    assign sum_valid = sum_valid_q;
    assign seq_err   = seq_err_q;
    assign busy      = (state_q == ACCUM);

endmodule

// File: tb/tb_pp_row_accumulator.sv
// Bench for pp_row_accumulator (DEPTH=4, Q=3329): a vector table with
// per-cycle expectations, hand sequences for error/gap/reset cases and a
// randomized phase checked against a row-level reference model.
module tb_pp_row_accumulator;

  localparam int DEPTH = 4;
  localparam int Q     = 3329;

  typedef struct {
    bit v;
    int idx;
    int h;
    int l0;
    int l1;
    int e;
  } beat_t;

  typedef struct {
    bit emit;
    int sum;
    int row;
    bit busy;
    bit err;
  } mres_t;

  typedef struct {
    beat_t b;
    int    sv;
    int    sum;
    int    row;
    int    err;
    int    busy;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        b_valid;
  logic [9:0]  idx;
  logic [9:0]  h;
  logic [31:0] b_data;
`ifdef PP_ERROR_TERM_EN
  logic [15:0] e_val;
`endif
  logic [15:0] sum_out;
  logic [9:0]  row_out;
  logic        sum_valid;
  logic        seq_err;
  logic        busy;

  always #5 clk = ~clk;

  pp_row_accumulator #(.DEPTH(DEPTH), .Q(Q)) dut (
    .clk_in    (clk),
    .rst_in    (rst_n),
    .B_valid   (b_valid),
    .idx_B     (idx),
    .B_out     (b_data),
    .h_in      (h),
`ifdef PP_ERROR_TERM_EN
    .e_in      (e_val),
`endif
    .sum_out   (sum_out),
    .row_out   (row_out),
    .sum_valid (sum_valid),
    .seq_err   (seq_err),
    .busy      (busy)
  );

  // ---------------- counters and scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int n_pulses = 0;
  logic [25:0] exp_q[$];
  int hold_sum = 0;
  int hold_row = 0;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // ---------------- reference model (row level) ----------------
  bit    m_active;
  bit    m_err;
  int    m_next;
  int    m_h;
  int    m_sum;
  mres_t r1;
  mres_t r2;

  function automatic int finish_sum(input int s, input int e);
`ifdef PP_ERROR_TERM_EN
    return (s + e) % Q;
`else
    return s + 0 * e;
`endif
  endfunction

  task automatic model_step(input beat_t b, output mres_t r);
    bit berr;
    r.emit = 1'b0;
    r.sum  = 0;
    r.row  = 0;
    if (b.v) begin
      berr = (b.l0 >= Q) || (b.l1 >= Q);
`ifdef PP_ERROR_TERM_EN
      if (b.idx == DEPTH - 1 && b.e >= Q) berr = 1'b1;
`endif
      if (m_active && !berr && b.idx == m_next && b.h == m_h) begin
        m_sum = (m_sum + b.l0 + b.l1) % Q;
        m_next++;
        if (b.idx == DEPTH - 1) begin
          r.emit   = 1'b1;
          r.sum    = finish_sum(m_sum, b.e);
          r.row    = m_h;
          m_active = 1'b0;
        end
      end else if (!berr && b.idx == 0) begin
        if (m_active) m_err = 1'b1;
        m_sum  = (b.l0 + b.l1) % Q;
        m_h    = b.h;
        m_next = 1;
        if (DEPTH == 1) begin
          r.emit = 1'b1;
          r.sum  = finish_sum(m_sum, b.e);
          r.row  = m_h;
        end else begin
          m_active = 1'b1;
        end
      end else begin
        m_err    = 1'b1;
        m_active = 1'b0;
      end
    end
    r.busy = m_active;
    r.err  = m_err;
  endtask

  // ---------------- driver tasks ----------------
  // Each call starts and ends just after a falling edge.
  task automatic step(input beat_t b);
    mres_t res;
    logic [25:0] got_exp;
    b_valid = b.v;
    idx     = b.idx[9:0];
    h       = b.h[9:0];
    b_data  = {b.l1[15:0], b.l0[15:0]};
`ifdef PP_ERROR_TERM_EN
    e_val   = b.e[15:0];
`endif
    @(posedge clk);
    #1;
    model_step(b, res);
    if (r2.emit) exp_q.push_back({r2.row[9:0], r2.sum[15:0]});
    chk("sum_valid", int'(sum_valid), int'(r2.emit));
    chk("busy", int'(busy), int'(r1.busy));
    chk("seq_err", int'(seq_err), int'(r1.err));
    if (sum_valid) begin
      n_pulses++;
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        got_exp  = exp_q.pop_front();
        hold_sum = int'(got_exp[15:0]);
        hold_row = int'(got_exp[25:16]);
      end
    end
    chk("sum_out", int'(sum_out), hold_sum);
    chk("row_out", int'(row_out), hold_row);
    r2 = r1;
    r1 = res;
    @(negedge clk);
  endtask

  task automatic beat(input int i, input int hh, input int a, input int b, input int e);
    beat_t x;
    x = '{v: 1'b1, idx: i, h: hh, l0: a, l1: b, e: e};
    step(x);
  endtask

  task automatic idle(input int n);
    beat_t x;
    x = '{v: 1'b0, idx: 0, h: 0, l0: 0, l1: 0, e: 0};
    for (int k = 0; k < n; k++) step(x);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    b_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    chk("rst_sum_out", int'(sum_out), 0);
    chk("rst_row_out", int'(row_out), 0);
    chk("rst_sum_valid", int'(sum_valid), 0);
    chk("rst_seq_err", int'(seq_err), 0);
    chk("rst_busy", int'(busy), 0);
    m_active = 1'b0;
    m_err    = 1'b0;
    m_next   = 0;
    m_h      = 0;
    m_sum    = 0;
    r1       = '{emit: 1'b0, sum: 0, row: 0, busy: 1'b0, err: 1'b0};
    r2       = r1;
    exp_q.delete();
    hold_sum = 0;
    hold_row = 0;
    rst_n    = 1'b1;
  endtask

  function automatic vec_t mv(input bit v, input int i, input int hh, input int a, input int b,
                              input int sv, input int s, input int r, input int er, input int bz);
    vec_t t;
    t.b    = '{v: v, idx: i, h: hh, l0: a, l1: b, e: 0};
    t.sv   = sv;
    t.sum  = s;
    t.row  = r;
    t.err  = er;
    t.busy = bz;
    return t;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main test ----------------
  initial begin
    vec_t tbl[36];
    int   p0;
    int   lanes_a[4];
    int   lanes_b[4];
    int   ref_sum;
    int   sum_a;
    int   sum_b;

    // inputs after each beat: {v idx h l0 l1} | expected after that edge {sv sum row err busy}
    tbl[0]  = mv(1, 0, 5, 1, 2,       0, 0, 0, 0, 0);
    tbl[1]  = mv(1, 1, 5, 3, 4,       0, 0, 0, 0, 1);
    tbl[2]  = mv(1, 2, 5, 3000, 300,  0, 0, 0, 0, 1);
    tbl[3]  = mv(1, 3, 5, 0, 0,       0, 0, 0, 0, 1);
    tbl[4]  = mv(0, 0, 0, 0, 0,       0, 0, 0, 0, 0);
    tbl[5]  = mv(0, 0, 0, 0, 0,       1, 3310, 5, 0, 0);
    tbl[6]  = mv(0, 0, 0, 0, 0,       0, 3310, 5, 0, 0);
    tbl[7]  = mv(1, 0, 1, 1, 1,       0, 3310, 5, 0, 0);
    tbl[8]  = mv(1, 1, 1, 1, 1,       0, 3310, 5, 0, 1);
    tbl[9]  = mv(1, 2, 1, 1, 1,       0, 3310, 5, 0, 1);
    tbl[10] = mv(1, 3, 1, 1, 1,       0, 3310, 5, 0, 1);
    tbl[11] = mv(1, 0, 2, 1, 1,       0, 3310, 5, 0, 0);
    tbl[12] = mv(1, 1, 2, 1, 1,       1, 8, 1, 0, 1);
    tbl[13] = mv(1, 2, 2, 1, 1,       0, 8, 1, 0, 1);
    tbl[14] = mv(1, 3, 2, 1, 1,       0, 8, 1, 0, 1);
    tbl[15] = mv(0, 0, 0, 0, 0,       0, 8, 1, 0, 0);
    tbl[16] = mv(0, 0, 0, 0, 0,       1, 8, 2, 0, 0);
    tbl[17] = mv(0, 0, 0, 0, 0,       0, 8, 2, 0, 0);
    tbl[18] = mv(1, 0, 7, 3328, 3328, 0, 8, 2, 0, 0);
    tbl[19] = mv(1, 1, 7, 3328, 1,    0, 8, 2, 0, 1);
    tbl[20] = mv(1, 2, 7, 0, 0,       0, 8, 2, 0, 1);
    tbl[21] = mv(1, 3, 7, 0, 0,       0, 8, 2, 0, 1);
    tbl[22] = mv(0, 0, 0, 0, 0,       0, 8, 2, 0, 0);
    tbl[23] = mv(0, 0, 0, 0, 0,       1, 3327, 7, 0, 0);
    tbl[24] = mv(1, 0, 9, 1, 1,       0, 3327, 7, 0, 0);
    tbl[25] = mv(1, 1, 9, 1, 1,       0, 3327, 7, 0, 1);
    tbl[26] = mv(1, 3, 9, 1, 1,       0, 3327, 7, 0, 1);
    tbl[27] = mv(0, 0, 0, 0, 0,       0, 3327, 7, 1, 0);
    tbl[28] = mv(0, 0, 0, 0, 0,       0, 3327, 7, 1, 0);
    tbl[29] = mv(1, 0, 3, 2, 2,       0, 3327, 7, 1, 0);
    tbl[30] = mv(1, 1, 3, 2, 2,       0, 3327, 7, 1, 1);
    tbl[31] = mv(1, 2, 3, 2, 2,       0, 3327, 7, 1, 1);
    tbl[32] = mv(1, 3, 3, 2, 2,       0, 3327, 7, 1, 1);
    tbl[33] = mv(0, 0, 0, 0, 0,       0, 3327, 7, 1, 0);
    tbl[34] = mv(0, 0, 0, 0, 0,       1, 16, 3, 1, 0);
    tbl[35] = mv(0, 0, 0, 0, 0,       0, 16, 3, 1, 0);

    rst_n   = 1'b0;
    b_valid = 1'b0;
    idx     = '0;
    h       = '0;
    b_data  = '0;
`ifdef PP_ERROR_TERM_EN
    e_val   = '0;
`endif
    @(negedge clk);
    do_reset();

    // Table: single row, back-to-back rows, wrap, idx-skip error then clean row.
    for (int i = 0; i < 36; i++) begin
      step(tbl[i].b);
      chk($sformatf("tbl%0d_sv", i), int'(sum_valid), tbl[i].sv);
      chk($sformatf("tbl%0d_sum", i), int'(sum_out), tbl[i].sum);
      chk($sformatf("tbl%0d_row", i), int'(row_out), tbl[i].row);
      chk($sformatf("tbl%0d_err", i), int'(seq_err), tbl[i].err);
      chk($sformatf("tbl%0d_busy", i), int'(busy), tbl[i].busy);
    end

    // h tag changes at idx=2: error, no emit.
    do_reset();
    p0 = n_pulses;
    beat(0, 4, 10, 10, 0);
    beat(1, 4, 10, 10, 0);
    beat(2, 6, 10, 10, 0);
    beat(3, 6, 10, 10, 0);
    idle(3);
    chk("hchg_err", int'(seq_err), 1);
    chk("hchg_pulses", n_pulses - p0, 0);

    // Lane out of range mid-row.
    do_reset();
    p0 = n_pulses;
    beat(0, 8, 1, 1, 0);
    beat(1, 8, 4000, 1, 0);
    idle(3);
    chk("lane_err", int'(seq_err), 1);
    chk("lane_busy", int'(busy), 0);
    chk("lane_pulses", n_pulses - p0, 0);

    // Gaps inside a row give the same sum as the gapless row.
    do_reset();
    ref_sum = 0;
    for (int i = 0; i < 4; i++) begin
      lanes_a[i] = $urandom_range(0, Q - 1);
      lanes_b[i] = $urandom_range(0, Q - 1);
      ref_sum = (ref_sum + lanes_a[i] + lanes_b[i]) % Q;
    end
    for (int i = 0; i < 4; i++) beat(i, 11, lanes_a[i], lanes_b[i], 0);
    idle(3);
    sum_a = int'(sum_out);
    for (int i = 0; i < 4; i++) begin
      idle($urandom_range(0, 4));
      beat(i, 11, lanes_a[i], lanes_b[i], 0);
    end
    idle(3);
    sum_b = int'(sum_out);
    chk("gap_ref", sum_a, ref_sum);
    chk("gap_same", sum_b, sum_a);
    chk("gap_err", int'(seq_err), 0);

    // Reset after idx=1: no emit, outputs cleared, next row correct.
    beat(0, 12, 100, 100, 0);
    beat(1, 12, 100, 100, 0);
    p0 = n_pulses;
    do_reset();
    idle(3);
    chk("mrst_pulses", n_pulses - p0, 0);
    for (int i = 0; i < 4; i++) beat(i, 12, 5, 6, 0);
    idle(3);
    chk("mrst_sum", int'(sum_out), 44);
    chk("mrst_row", int'(row_out), 12);

`ifdef PP_ERROR_TERM_EN
    // Error term added at emit; out-of-range term drops the row.
    do_reset();
    beat(0, 5, 1, 2, 0);
    beat(1, 5, 3, 4, 0);
    beat(2, 5, 3000, 300, 0);
    beat(3, 5, 0, 0, 20);
    idle(3);
    chk("eterm_sum", int'(sum_out), 1);
    chk("eterm_row", int'(row_out), 5);
    p0 = n_pulses;
    beat(0, 6, 1, 2, 0);
    beat(1, 6, 3, 4, 0);
    beat(2, 6, 5, 6, 0);
    beat(3, 6, 7, 8, 3329);
    idle(3);
    chk("eterm_err", int'(seq_err), 1);
    chk("eterm_pulses", n_pulses - p0, 0);
`endif

    // Randomized rows with gaps and occasional protocol faults.
    do_reset();
    for (int row = 0; row < 80; row++) begin
      int hh;
      hh = $urandom_range(0, 1023);
      for (int i = 0; i < DEPTH; i++) begin
        int kind;
        int bi;
        int bh;
        int a;
        int b;
        int e;
        idle($urandom_range(0, 2) == 0 ? $urandom_range(1, 3) : 0);
        kind = $urandom_range(0, 39);
        bi = i;
        bh = hh;
        a  = $urandom_range(0, Q - 1);
        b  = $urandom_range(0, Q - 1);
        e  = $urandom_range(0, Q - 1);
        if (kind == 0) a = $urandom_range(Q, 65535);
        if (kind == 1) bi = $urandom_range(0, 1023);
        if (kind == 2) bh = $urandom_range(0, 1023);
        if (kind == 3) e = $urandom_range(Q, 65535);
        beat(bi, bh, a, b, e);
      end
      if ($urandom_range(0, 7) == 0) do_reset();
    end
    idle(4);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pp_row_accumulator.md
Name: pp_row_accumulator

Overview:
- Receiver end of the partial-product stream from the public/private multiply stage.
- Each beat carries two 16-bit lanes that are already masked by the secret bits.
- The block reduces each beat's lane pair mod Q and accumulates DEPTH consecutive beats of one row.
- It emits one row sum per row, tagged with the row's h tag, to the downstream key/ciphertext assembly logic.

Parameters:
- DEPTH, 100, number of 32-bit beats (lane pairs) per row; legal range 1..1024.
- Q, 3329, modulus; Q < 2^15 so that a 16-bit sum of two reduced values cannot overflow.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-low reset
- B_valid  input  1  beat valid
- idx_B  input  10  beat index within row, 0..DEPTH-1
- B_out  input  32  lane1 in [31:16], lane0 in [15:0]
- h_in  input  10  row tag, constant across a row
- sum_out  output  16  row sum mod Q
- row_out  output  10  h tag of emitted row
- sum_valid  output  1  one-cycle pulse, row sum valid
- seq_err  output  1  sticky protocol/range error flag
- busy  output  1  high while a row is partially accumulated

Behaviour:
- Reset (rst_in low at a clock edge): sum_out=0, row_out=0, sum_valid=0, seq_err=0, busy=0, FSM=IDLE, all pipeline valids=0.
- No backpressure. A beat is accepted on every cycle with B_valid=1.
- Stage 1 (registered): lane_sum = (lane0 + lane1) mod Q, one conditional subtract. idx_B, h_in and B_valid are registered alongside.
- Range check: if either lane is >= Q, the beat sets seq_err and is treated as a sequence error.
- Stage 2: the FSM consumes stage-1 beats.
- FSM IDLE:
  - Beat with idx=0: acc <= lane_sum, cur_row <= h, expect <= 1, go to ACCUM.
  - If DEPTH=1, emit immediately and stay in IDLE.
  - Beat with idx != 0: set seq_err, drop the beat, stay in IDLE.
- FSM ACCUM:
  - Beat with idx=expect and h=cur_row: acc <= (acc + lane_sum) mod Q, expect++.
  - If idx = DEPTH-1: emit and go to IDLE.
- Emit: sum_out <= final acc, row_out <= cur_row, sum_valid=1 for exactly one cycle. sum_out and row_out hold until the next emit.
- Latency: sum_valid asserts 2 cycles after the clock edge that accepted the last beat (idx=DEPTH-1).
- Back-to-back rows: an idx=0 beat may directly follow idx=DEPTH-1 with no gap. The new row loads the accumulator in the same cycle the previous row emits, and no beat is lost.
- Sequence error in ACCUM (wrong idx, h change, or lane out of range):
  - Set seq_err, discard the partial row, no emit.
  - If the offending beat has idx=0 and in-range lanes, it starts a new row. Otherwise go to IDLE.
- Gaps: B_valid low for any number of cycles mid-row is legal; the FSM holds state.
- busy = (FSM == ACCUM).
- seq_err clears only on reset.
- Reset mid-row: the partial row is discarded, no emit, and sum_valid stays low on the cycle after reset releases.
- Arithmetic: all adds are 16-bit unsigned followed by one conditional subtract of Q. Operands are always < Q.

Optional Feature:
- Macro: PP_ERROR_TERM_EN.
- When defined:
  - Extra input e_in (16 bits, must be < Q), sampled with the idx=DEPTH-1 beat and pipelined with it.
  - Emitted sum_out = (acc + e_in) mod Q. Emit latency is unchanged.
  - e_in >= Q sets seq_err and the row is dropped.
- When undefined: no e_in port, and sum_out is the plain row sum.

Decomposition:
- Package lwe_pkg holds:
  - localparam LANE_W=16 and IDX_W=10;
  - typedef lane_t (logic [15:0]);
  - typedef idx_t (logic [9:0]);
  - enum acc_state_t {IDLE, ACCUM};
  - default Q.
- One sub-module mod_add_q (combinational: a+b, one conditional subtract of Q, parameter Q), instantiated for the lane add, the accumulate and, under the macro, the error add.

Test Plan:
- Single row: DEPTH=4, Q=3329, h=5, beats idx0..3 with lanes (1,2),(3,4),(3000,300),(0,0) -> one sum_valid, sum_out=(3+7+3300+0) mod 3329=3310, row_out=5, 2 cycles after idx=3.
- Wrap: DEPTH=2, lanes (3328,3328),(3328,1) -> lane sums 3327 and 0, sum_out=3327; no overflow.
- Back-to-back: two rows h=1 then h=2, DEPTH=4, all lanes (1,1), no gaps -> two pulses 4 cycles apart, each sum_out=8, row_out 1 then 2; seq_err=0.
- Errors:
  - idx sequence 0,1,3 -> seq_err=1, no emit, busy=0;
  - then a clean row -> emits correctly with seq_err still 1;
  - h changes at idx=2 -> seq_err=1, no emit;
  - lane 4000 -> seq_err=1.
- Gaps and reset: random B_valid gaps inside a row -> same sum as gapless. Reset pulse after idx=1 -> all outputs 0 and no pulse; a subsequent row is correct.
- PP_ERROR_TERM_EN: first test with e_in=20 -> sum_out=1 ((3310+20) mod 3329); e_in=3329 -> seq_err=1, no emit.
